// File: rtl/reg_file_mp.sv
// Two-write-port register file with forwarding, optional hardwired zero entry,
// per-register pending bits and a one-entry-per-cycle clear sweep.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] wa_a,
   input  logic [DATA_W-1:0] wd_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] wa_b,
   input  logic [DATA_W-1:0] wd_b,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              pend1,
   output logic              pend2,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   logic [ADDR_W-1:0] ra_v   [2];
   logic [DATA_W-1:0] rd_v   [2];
   logic              pend_v [2];
   logic              bypass_en;

   function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
      return ZERO_REG && (addr == '0);
   endfunction

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      mem_d   = mem_q;
      pend_d  = pend_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            // Port B is applied last so it wins an address collision.
            if (we_a && !is_zero(wa_a)) mem_d[wa_a] = wd_a;
            if (we_b && !is_zero(wa_b)) mem_d[wa_b] = wd_b;
            if (we_b) pend_d[wa_b] = 1'b0;
            if (pend_set && !is_zero(pend_addr)) pend_d[pend_addr] = 1'b1;
            if (clr_req) begin
               state_d = ST_CLEAR;
               pend_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the array is reset explicitly; a clean post-reset register file is required.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         pend_q  <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         mem_q   <= mem_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ra_v[0]   = ra1;
   assign ra_v[1]   = ra2;
   assign bypass_en = BYPASS && reset && (state_q == ST_IDLE);

   // Forwarding is gated by reset so the outputs stay at zero while it is held.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_v[p] = mem_q[ra_v[p]];
         if (bypass_en && we_a && (wa_a == ra_v[p])) rd_v[p] = wd_a;
         if (bypass_en && we_b && (wa_b == ra_v[p])) rd_v[p] = wd_b;
         if (!reset || is_zero(ra_v[p])) rd_v[p] = '0;
         pend_v[p] = reset && pend_q[ra_v[p]] && !is_zero(ra_v[p]);
      end
   end

   assign rd1      = rd_v[0];
   assign rd2      = rd_v[1];
   assign pend1    = pend_v[0];
   assign pend2    = pend_v[1];
   assign clr_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp against an array-based model.
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ra1, ra2, wa_a, wa_b, pend_addr;
   logic [DW-1:0] rd1, rd2, wd_a, wd_b;
   logic          we_a, we_b, pend_set, pend1, pend2, clr_req, clr_busy;

   int checks   = 0;
   int failures = 0;

   // Model: stored words, pending flags and the position of an ongoing sweep.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];
   bit            m_clear;
   int            m_idx;

   always #5 clk = ~clk;

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
      .pend_set(pend_set), .pend_addr(pend_addr), .pend1(pend1), .pend2(pend2),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (!reset || a == 0) return '0;
      if (!m_clear && we_b && wa_b == a) return wd_b;
      if (!m_clear && we_a && wa_a == a) return wd_a;
      return m_mem[a];
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] a);
      return reset && m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_clear = 1'b0;
      m_idx   = 0;
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
      end else if (m_clear) begin
         m_mem[m_idx] = '0;
         m_idx++;
         if (m_idx == DEPTH) begin
            m_clear = 1'b0;
            m_idx   = 0;
         end
      end else begin
         if (we_a && wa_a != 0) m_mem[wa_a] = wd_a;
         if (we_b && wa_b != 0) m_mem[wa_b] = wd_b;
         if (we_b) m_pend[wa_b] = 1'b0;
         if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
         if (clr_req) begin
            m_clear = 1'b1;
            m_idx   = 0;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
         end
      end
   endtask

   task automatic idle_in();
      we_a = 0; wa_a = '0; wd_a = '0;
      we_b = 0; wa_b = '0; wd_b = '0;
      pend_set = 0; pend_addr = '0; clr_req = 0;
   endtask

   // Called at a falling edge with inputs driven; checks, clocks the model, returns at the next falling edge.
   task automatic step();
      #2;
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
      check("pend1", pend1, exp_pend(ra1));
      check("pend2", pend2, exp_pend(ra2));
      check("clr_busy", clr_busy, reset && m_clear);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic read_all(input string tag);
      idle_in();
      for (int i = 0; i < DEPTH; i++) begin
         ra1 = AW'(i);
         ra2 = AW'(DEPTH - 1 - i);
         #1;
         check(tag, rd1, '0);
         step();
      end
   endtask

   task automatic wait_idle();
      idle_in();
      for (int i = 0; i < 2 * DEPTH && m_clear; i++) step();
      check("wait_idle", clr_busy, 1'b0);
   endtask

   initial begin
      int busy_cnt;
      idle_in();
      ra1 = '0; ra2 = '0;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      step(); step();
      reset = 1'b1;
      step();

      // Preload every writable entry with all-ones, then reset.
      for (int i = 1; i < DEPTH; i++) begin
         we_a = 1; wa_a = AW'(i); wd_a = 32'hFFFF_FFFF;
         ra1 = AW'(i); ra2 = AW'(DEPTH - 1);
         step();
      end
      idle_in();
      ra1 = 5'd31; ra2 = 5'd31;
      #1 check("preload_31", rd1, 32'hFFFF_FFFF);
      reset = 1'b0;
      we_b = 1; wa_b = 5'd5; wd_b = 32'h1111_2222; ra1 = 5'd5;
      #1;
      check("rst_rd1", rd1, '0);
      check("rst_busy", clr_busy, 1'b0);
      step(); step();
      reset = 1'b1;
      read_all("rst_clear");

      // Same-address write collision: port B wins, forwarded and stored.
      we_a = 1; wa_a = 5'd5; wd_a = 32'h1234_5678;
      we_b = 1; wa_b = 5'd5; wd_b = 32'hCAFE_F00D;
      ra1 = 5'd5; ra2 = 5'd6;
      #1 check("coll_bypass", rd1, 32'hCAFE_F00D);
      step();
      idle_in();
      #1 check("coll_stored", rd1, 32'hCAFE_F00D);
      step();

      // Zero register ignores writes and pending marks.
      we_a = 1; wa_a = '0; wd_a = 32'hDEAD_BEEF;
      pend_set = 1; pend_addr = '0; ra1 = '0;
      #1 check("zero_bypass", rd1, '0);
      step();
      idle_in();
      #1;
      check("zero_rd", rd1, '0);
      check("zero_pend", pend1, 1'b0);
      step();

      // Pending bit: set, set+clear same cycle, clear.
      pend_set = 1; pend_addr = 5'd7; ra1 = 5'd7;
      step();
      idle_in();
      #1 check("pend_set", pend1, 1'b1);
      pend_set = 1; pend_addr = 5'd7; we_b = 1; wa_b = 5'd7; wd_b = 32'h0000_0077;
      step();
      idle_in();
      #1 check("pend_both", pend1, 1'b1);
      we_b = 1; wa_b = 5'd7; wd_b = 32'h0000_0078;
      step();
      idle_in();
      #1 check("pend_clr", pend1, 1'b0);
      step();

      // Random traffic with occasional sweeps.
      for (int n = 0; n < 500; n++) begin
         we_a = 1'($urandom_range(0, 1)); wa_a = AW'($urandom); wd_a = $urandom;
         we_b = 1'($urandom_range(0, 1)); wa_b = AW'($urandom_range(0, 7)); wd_b = $urandom;
         pend_set = 1'($urandom_range(0, 1)); pend_addr = AW'($urandom_range(0, 7));
         clr_req = ($urandom_range(0, 59) == 0);
         ra1 = ($urandom_range(0, 1) == 1) ? wa_b : AW'($urandom);
         ra2 = ($urandom_range(0, 1) == 1) ? wa_a : AW'($urandom_range(0, 7));
         step();
      end
      wait_idle();

      // Full sweep: exact busy length, dropped write, ignored re-request.
      for (int i = 0; i < DEPTH; i++) begin
         we_b = 1; wa_b = AW'(i); wd_b = 32'h0101_0101 * (i + 1);
         step();
      end
      idle_in();
      clr_req = 1;
      step();
      idle_in();
      busy_cnt = 0;
      for (int c = 0; c < DEPTH + 8; c++) begin
         if (c == 5) begin we_a = 1; wa_a = 5'd3; wd_a = 32'h5555_AAAA; end
         if (c == 12) clr_req = 1;
         ra1 = 5'd3; ra2 = AW'(c % DEPTH);
         #1 if (clr_busy) busy_cnt++;
         step();
         idle_in();
      end
      check("busy_len", 32'(busy_cnt), 32'(DEPTH));
      read_all("sweep_zero");

      // Reset in the middle of a sweep.
      for (int i = 1; i < DEPTH; i++) begin
         we_a = 1; wa_a = AW'(i); wd_a = 32'hA5A5_0000 + i;
         step();
      end
      idle_in();
      pend_set = 1; pend_addr = 5'd4;
      step();
      idle_in();
      ra1 = 5'd4;
      #1 check("pend4", pend1, 1'b1);
      clr_req = 1;
      step();
      idle_in();
      for (int c = 0; c < 10; c++) step();
      #1 reset = 1'b0;
      #1 check("midrst_busy", clr_busy, 1'b0);
      step();
      reset = 1'b1;
      step();
      check("midrst_idle", clr_busy, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         ra1 = AW'(i); ra2 = AW'(i);
         #1;
         check("midrst_mem", rd1, '0);
         check("midrst_pend", pend2, 1'b0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the single-cycle register file. It adds a second write port for load writeback, optional write-to-read bypass, a hardwired zero register, and per-register pending (scoreboard) bits. It also has a sequential clear engine that zeroes the array without a global reset. It sits in the decode/writeback path of the next-generation core.

Parameters:
DATA_W, 32, data width of each entry
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, is never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
ra1  in  ADDR_W  read address 1
ra2  in  ADDR_W  read address 2
rd1  out  DATA_W  read data 1, combinational
rd2  out  DATA_W  read data 2, combinational
we_a  in  1  write enable, port A (ALU writeback)
wa_a  in  ADDR_W  write address A
wd_a  in  DATA_W  write data A
we_b  in  1  write enable, port B (load writeback)
wa_b  in  ADDR_W  write address B
wd_b  in  DATA_W  write data B
pend_set  in  1  mark pend_addr pending (load issued)
pend_addr  in  ADDR_W  register to mark pending
pend1  out  1  pending bit of ra1, combinational from registered state
pend2  out  1  pending bit of ra2
clr_req  in  1  single-cycle request to start a clear sweep
clr_busy  out  1  high while the clear sweep runs

Behaviour:
- Reset (reset=0, async):
  - all DEPTH entries = 0, including the top entry;
  - all pending bits = 0;
  - FSM = IDLE, sweep counter = 0, clr_busy = 0;
  - rd1/rd2 = 0 and pend1/pend2 = 0 while reset is held.
- Writes: committed on posedge when we_x=1; visible to the raw array read in the next cycle.
- Write collision: we_a and we_b to the same address in the same cycle -> port B data is stored.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - rd for address 0 is always 0, including the bypass path;
  - pend_set to address 0 is ignored.
- BYPASS=1: if ra matches an active write address in the current cycle, rd returns that write data.
  - Port B has priority over port A.
  - Bypass is suppressed during CLEAR.
- BYPASS=0: rd returns the stored entry only.
- Pending bits:
  - pend_set sets bit[pend_addr] at posedge.
  - we_b clears bit[wa_b] at posedge.
  - pend_set and we_b to the same address in the same cycle -> bit ends up set (the new load wins).
  - we_a does not affect pending bits.
- FSM IDLE:
  - clr_req=1 -> CLEAR at the next posedge;
  - on that edge all pending bits are cleared and the counter is loaded with 0.
- FSM CLEAR, each cycle:
  - entry[counter] <= 0, counter += 1;
  - we_a, we_b and pend_set are dropped;
  - reads return current array contents, so a partially cleared view is legal;
  - clr_req is ignored.
- CLEAR exit: after writing entry DEPTH-1, FSM -> IDLE and the counter wraps to 0.
- clr_busy:
  - high exactly DEPTH cycles, starting the cycle after clr_req is sampled;
  - combinational from FSM state (clr_busy = state==CLEAR).
- Reset asserted mid-sweep: immediate return to IDLE with all state per reset values.
- No debug file dump; the array is observable hierarchically only.

Test Plan:
- Reset with all entries preloaded to 32'hFFFF_FFFF, then reset=0 -> every entry, including 31, reads 0; pend1=pend2=0; clr_busy=0.
- we_a addr 5 = 32'h1234_5678 and we_b addr 5 = 32'hCAFE_F00D in the same cycle, ra1=5 -> rd1=32'hCAFE_F00D that cycle (bypass) and after the edge.
- ZERO_REG=1: we_a addr 0 = 32'hDEAD_BEEF, pend_set addr 0 -> rd1 for ra1=0 is 0 every cycle; pend1=0.
- pend_set addr 7, next cycle pend1=1 for ra1=7; then pend_set 7 and we_b 7 in the same cycle -> pend1 stays 1; then we_b 7 alone -> pend1=0.
- Fill all 32 entries with nonzero values, pulse clr_req -> clr_busy high exactly 32 cycles; a we_a to addr 3 mid-sweep is dropped; all entries 0 after the sweep; a second clr_req mid-sweep has no effect.
- Assert reset at sweep cycle 10 with pend bit 4 set -> clr_busy=0 immediately; after release, all entries and pending bits are 0 and the FSM is IDLE.
